// File: rtl/result_collector.sv
// rtl/result_collector.sv - captures indexed matrix results into a buffer and drains them row-major over valid/ready
module result_collector #(
    parameter int R_A = 2,
    parameter int C_B = 2,
    parameter int DW  = 32,
    parameter int IW  = 32,
    localparam int TOTAL = R_A * C_B,
    localparam int CW    = $clog2(TOTAL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          res_ack,
    input  logic [DW-1:0] result,
    input  logic [IW-1:0] res_i,
    input  logic [IW-1:0] res_j,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [IW-1:0] out_row,
    output logic [IW-1:0] out_col,
    output logic [CW-1:0] count,
    output logic          done,
    output logic          err_range,
    output logic          err_dup,
    output logic          err_ovf
);

    localparam int AW = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        FINISH  = 2'd2
    } state_t;

    state_t              state;
    logic [DW-1:0]       mem [TOTAL];
    logic [TOTAL-1:0]    filled;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       idx;
    logic                in_range;
    logic                wr_en;

    assign in_range = (res_i < IW'(R_A)) && (res_j < IW'(C_B));
    assign idx      = AW'(res_i * IW'(C_B) + res_j);
    assign wr_en    = !clr && (state == COLLECT) && res_ack && in_range && !filled[idx];

    // Drain outputs follow rd_ptr directly and read as zero whenever nothing is offered.
    assign out_data = out_valid ? mem[rd_ptr] : '0;
    assign out_row  = out_valid ? IW'(IW'(rd_ptr) / IW'(C_B)) : '0;
    assign out_col  = out_valid ? IW'(IW'(rd_ptr) % IW'(C_B)) : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            count     <= '0;
            filled    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err_range <= 1'b0;
            err_dup   <= 1'b0;
            err_ovf   <= 1'b0;
        end else if (clr) begin
            state     <= COLLECT;
            count     <= '0;
            filled    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err_range <= 1'b0;
            err_dup   <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (res_ack && !in_range) begin
                        err_range <= 1'b1;
                    end else if (res_ack && filled[idx]) begin
                        err_dup <= 1'b1;
                    end
                    if (wr_en) begin
                        filled[idx] <= 1'b1;
                        count       <= count + CW'(1);
                        if (count == CW'(TOTAL - 1)) begin
                            state     <= DRAIN;
                            rd_ptr    <= '0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (res_ack) begin
                        err_ovf <= 1'b1;
                    end
                    if (out_ready) begin
                        if (rd_ptr == AW'(TOTAL - 1)) begin
                            state     <= FINISH;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + AW'(1);
                        end
                    end
                end
                FINISH: begin
                    if (res_ack) begin
                        err_ovf <= 1'b1;
                    end
                end
                default: begin
                    state     <= COLLECT;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - randomized self-checking bench for result_collector
module tb_result_collector;

    localparam int RA    = 2;
    localparam int CB    = 2;
    localparam int DW    = 32;
    localparam int IW    = 32;
    localparam int TOTAL = RA * CB;
    localparam int CW    = $clog2(TOTAL + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          res_ack = 1'b0;
    logic [DW-1:0] result = '0;
    logic [IW-1:0] res_i = '0;
    logic [IW-1:0] res_j = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_row;
    logic [IW-1:0] out_col;
    logic [CW-1:0] count;
    logic          done;
    logic          err_range;
    logic          err_dup;
    logic          err_ovf;

    int checks = 0;
    int errors = 0;

    // Reference model: what has been captured, keyed by row-major position.
    logic [DW-1:0] m_mem [TOTAL];
    bit            m_filled [TOTAL];
    int            m_count;
    bit            m_er, m_ed, m_eo;

    result_collector #(.R_A(RA), .C_B(CB), .DW(DW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .res_ack(res_ack), .result(result),
        .res_i(res_i), .res_j(res_j), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col), .count(count),
        .done(done), .err_range(err_range), .err_dup(err_dup), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_count = 0;
        m_er = 0;
        m_ed = 0;
        m_eo = 0;
        for (int k = 0; k < TOTAL; k++) m_filled[k] = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic send(input int i, input int j, input logic [DW-1:0] v);
        res_ack = 1'b1;
        res_i   = IW'(i);
        res_j   = IW'(j);
        result  = v;
        @(posedge clk);
        if (m_count < TOTAL) begin
            if (i < RA && j < CB) begin
                if (m_filled[i*CB+j]) m_ed = 1;
                else begin
                    m_mem[i*CB+j]    = v;
                    m_filled[i*CB+j] = 1;
                    m_count++;
                end
            end else m_er = 1;
        end else m_eo = 1;
        @(negedge clk);
        res_ack = 1'b0;
    endtask

    task automatic test_reset();
        send(0, 0, 32'd1);
        send(2, 2, 32'd9);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, done, err_range, err_dup, err_ovf, count, out_data, out_row, out_col} !== '0) begin
            errors++;
            $display("FAIL reset_async: got v=%b d=%b er=%b cnt=%0d data=%h, required all zero",
                     out_valid, done, err_range, count, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        step();
        checks++;
        if ({count, err_range, done} !== '0) begin
            errors++;
            $display("FAIL reset_release: got cnt=%0d er=%b d=%b, required 0", count, err_range, done);
        end
    endtask

    task automatic test_in_order();
        logic signed [DW-1:0] exp_v [4];
        exp_v = '{32'sd10, 32'sd20, 32'sd30, -32'sd40};
        hard_reset();
        out_ready = 1'b1;
        send(0, 0, exp_v[0]);
        send(0, 1, exp_v[1]);
        send(1, 0, exp_v[2]);
        send(1, 1, exp_v[3]);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_v[k] || out_row !== 32'(k / 2)
                || out_col !== 32'(k % 2) || done !== 1'b0) begin
                errors++;
                $display("FAIL in_order[%0d]: got v=%b data=%0d row=%0d col=%0d d=%b, required v=1 data=%0d row=%0d col=%0d d=0",
                         k, out_valid, $signed(out_data), out_row, out_col, done, exp_v[k], k / 2, k % 2);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || count !== CW'(4)) begin
            errors++;
            $display("FAIL in_order_done: got d=%b v=%b cnt=%0d, required d=1 v=0 cnt=4", done, out_valid, count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_scramble(input bit directed);
        int ord [TOTAL];
        logic [DW-1:0] vals [TOTAL];
        int k, cyc, r, tmp;
        bit rdy;
        if (directed) begin
            hard_reset();
            ord  = '{3, 0, 2, 1};
            vals = '{32'd1, 32'd2, 32'd3, 32'd4};
        end else begin
            clr = 1'b1;
            step();
            clr = 1'b0;
            model_clear();
            checks++;
            if ({count, done, out_valid, err_range, err_dup, err_ovf} !== '0) begin
                errors++;
                $display("FAIL clr_restart: got cnt=%0d d=%b v=%b errs=%b%b%b, required all 0",
                         count, done, out_valid, err_range, err_dup, err_ovf);
            end
            for (int n = 0; n < TOTAL; n++) begin
                ord[n]  = n;
                vals[n] = $urandom;
            end
            for (int n = TOTAL - 1; n > 0; n--) begin
                r = $urandom_range(0, n);
                tmp = ord[n]; ord[n] = ord[r]; ord[r] = tmp;
            end
        end
        for (int n = 0; n < TOTAL; n++) begin
            if (directed) step();
            else begin
                repeat ($urandom_range(0, 2)) step();
                if ($urandom_range(0, 3) == 0) send(RA + $urandom_range(0, 3), $urandom_range(0, CB - 1), $urandom);
                if (n > 0 && $urandom_range(0, 3) == 0) send(ord[0] / CB, ord[0] % CB, $urandom);
            end
            send(ord[n] / CB, ord[n] % CB, vals[ord[n]]);
        end
        checks++;
        if (out_valid !== 1'b1 || count !== CW'(m_count) || {err_range, err_dup, err_ovf} !== {m_er, m_ed, m_eo}) begin
            errors++;
            $display("FAIL fill_state: got v=%b cnt=%0d errs=%b%b%b, required v=1 cnt=%0d errs=%b%b%b",
                     out_valid, count, err_range, err_dup, err_ovf, m_count, m_er, m_ed, m_eo);
        end
        k = 0;
        cyc = 0;
        while (k < TOTAL && cyc < 500) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== m_mem[k] || out_row !== 32'(k / CB) || out_col !== 32'(k % CB)) begin
                errors++;
                $display("FAIL drain[%0d]: got v=%b data=%h row=%0d col=%0d, required v=1 data=%h row=%0d col=%0d",
                         k, out_valid, out_data, out_row, out_col, m_mem[k], k / CB, k % CB);
            end
            rdy = directed ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            out_ready = rdy;
            step();
            if (rdy) k++;
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (k != TOTAL || done !== 1'b1 || out_valid !== 1'b0 || count !== CW'(TOTAL)) begin
            errors++;
            $display("FAIL drain_end: got k=%0d d=%b v=%b cnt=%0d, required k=%0d d=1 v=0 cnt=%0d",
                     k, done, out_valid, count, TOTAL, TOTAL);
        end
    endtask

    task automatic test_dup();
        hard_reset();
        send(0, 0, 32'd5);
        send(0, 0, 32'd7);
        checks++;
        if (count !== CW'(1) || err_dup !== 1'b1 || err_range !== 1'b0 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL dup_flags: got cnt=%0d ed=%b er=%b eo=%b, required cnt=1 ed=1 er=0 eo=0",
                     count, err_dup, err_range, err_ovf);
        end
        send(0, 1, 32'd6);
        send(1, 0, 32'd8);
        send(1, 1, 32'd9);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd5) begin
            errors++;
            $display("FAIL dup_first_wins: got v=%b data=%0d, required v=1 data=5", out_valid, out_data);
        end
    endtask

    task automatic test_range_ovf();
        hard_reset();
        send(2, 0, 32'd99);
        send(0, 3, 32'd98);
        checks++;
        if (count !== CW'(0) || err_range !== 1'b1 || err_dup !== 1'b0) begin
            errors++;
            $display("FAIL range: got cnt=%0d er=%b ed=%b, required cnt=0 er=1 ed=0", count, err_range, err_dup);
        end
        for (int n = 0; n < TOTAL; n++) send(n / CB, n % CB, $urandom);
        send(1, 1, 32'd123);
        checks++;
        if (err_ovf !== 1'b1 || out_data !== m_mem[0] || count !== CW'(TOTAL)) begin
            errors++;
            $display("FAIL ovf_drain: got eo=%b data=%h cnt=%0d, required eo=1 data=%h cnt=%0d",
                     err_ovf, out_data, count, m_mem[0], TOTAL);
        end
        out_ready = 1'b1;
        for (int k = 0; k < TOTAL; k++) begin
            checks++;
            if (out_data !== m_mem[k]) begin
                errors++;
                $display("FAIL ovf_intact[%0d]: got %h, required %h", k, out_data, m_mem[k]);
            end
            step();
        end
        out_ready = 1'b0;
        send(0, 0, 32'd1);
        checks++;
        if (done !== 1'b1 || err_ovf !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_done: got d=%b eo=%b v=%b, required d=1 eo=1 v=0", done, err_ovf, out_valid);
        end
    endtask

    task automatic test_rst_drain();
        hard_reset();
        for (int n = 0; n < TOTAL; n++) send(n / CB, n % CB, $urandom);
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        checks++;
        if (out_data !== m_mem[2] || out_row !== 32'd1 || out_col !== 32'd0) begin
            errors++;
            $display("FAIL pre_rst_ptr: got data=%h row=%0d col=%0d, required data=%h row=1 col=0",
                     out_data, out_row, out_col, m_mem[2]);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, done, count, out_data, out_row, out_col, err_range, err_dup, err_ovf} !== '0) begin
            errors++;
            $display("FAIL rst_in_drain: got v=%b d=%b cnt=%0d data=%h, required all zero",
                     out_valid, done, count, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_clr_ack();
        hard_reset();
        send(2, 2, 32'd1);
        send(0, 0, 32'd8);
        clr     = 1'b1;
        res_ack = 1'b1;
        res_i   = 32'd1;
        res_j   = 32'd1;
        result  = 32'd77;
        step();
        clr     = 1'b0;
        res_ack = 1'b0;
        model_clear();
        checks++;
        if ({count, err_range, err_dup, err_ovf, out_valid} !== '0) begin
            errors++;
            $display("FAIL clr_ack: got cnt=%0d er=%b ed=%b eo=%b v=%b, required all 0",
                     count, err_range, err_dup, err_ovf, out_valid);
        end
        send(1, 1, 32'd55);
        send(0, 0, 32'd56);
        checks++;
        if (count !== CW'(2) || err_dup !== 1'b0) begin
            errors++;
            $display("FAIL clr_dropped: got cnt=%0d ed=%b, required cnt=2 ed=0", count, err_dup);
        end
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        test_reset();
        test_in_order();
        test_scramble(1'b1);
        test_dup();
        test_range_ovf();
        test_rst_drain();
        test_clr_ack();
        repeat (8) test_scramble(1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
